id_decode_stage: RTL and testbench

- Pipelined decode stage sitting directly upstream of the ALU source-select/extension stage.
- Accepts 32-bit RV32I instruction words from fetch over a valid/ready handshake.
- Decodes each word into the 5-bit operation-select code, the 12-bit and 20-bit immediates, and the register indices consumed downstream.
- Has a 2-entry skid buffer, so in_ready is a registered signal with no combinational path from out_ready.

---
 rtl/id_decode_stage.sv | 172 +++++++++++++++++
 tb/tb_id_decode_stage.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_decode_stage.sv
// RV32I decode stage with a 2-entry skid buffer; in_ready is a pure flop output.
// Optional illegal-opcode flagging is enabled by defining ID_DECODE_ILLEGAL_EN.
module id_decode_stage #(
  parameter int XLEN = 32,
  parameter int OP_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OP_W-1:0] out_op2,
  output logic [11:0]     out_imm_12,
  output logic [19:0]     out_imm_20,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic            out_reg_write,
  output logic [XLEN-1:0] out_pc
`ifdef ID_DECODE_ILLEGAL_EN
  ,
  output logic            out_illegal,
  output logic            illegal_seen
`endif
);

  localparam logic [OP_W-1:0] OP_OTHER = OP_W'(0);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(1);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SRAI  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_LUI   = OP_W'(4);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [OP_W-1:0] op2;
    logic [11:0]     imm_12;
    logic [19:0]     imm_20;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            reg_write;
`ifdef ID_DECODE_ILLEGAL_EN
    logic            illegal;
`endif
  } entry_t;

  entry_t     dec;
  entry_t     out_d, out_q;
  entry_t     skid_d, skid_q;
  logic       out_valid_d, out_valid_q;
  logic       skid_valid_d, skid_valid_q;
  logic       in_fire, out_fire;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  always_comb begin
    dec           = '0;
    dec.pc        = in_pc;
    dec.rs1       = in_instr[19:15];
    dec.rs2       = in_instr[24:20];
    dec.rd        = in_instr[11:7];
    dec.op2       = OP_OTHER;
    if (opcode == 7'b0000011 && funct3 == 3'b010) begin
      dec.op2       = OP_LW;
      dec.imm_12    = in_instr[31:20];
      dec.reg_write = 1'b1;
    end else if (opcode == 7'b0100011 && funct3 == 3'b010) begin
      dec.op2       = OP_SW;
      dec.imm_12    = {in_instr[31:25], in_instr[11:7]};
    end else if (opcode == 7'b0010011 && funct3 == 3'b101 && funct7 == 7'b0100000) begin
      dec.op2       = OP_SRAI;
      dec.imm_12    = in_instr[31:20];
      dec.reg_write = 1'b1;
    end else if (opcode == 7'b0110111) begin
      dec.op2       = OP_LUI;
      dec.imm_20    = in_instr[31:12];
      dec.reg_write = 1'b1;
    end
`ifdef ID_DECODE_ILLEGAL_EN
    case (opcode)
      7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011,
      7'b0100011, 7'b0010011, 7'b0110011, 7'b1110011, 7'b0001111:
        dec.illegal = (in_instr[1:0] != 2'b11);
      default:
        dec.illegal = 1'b1;
    endcase
`endif
  end

  assign in_fire  = in_valid & ~skid_valid_q & ~flush;
  assign out_fire = out_valid_q & out_ready;

  // Skid entry is always older than any new input, so it refills the output before fetch does.
  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q) begin
      if (in_fire) begin
        out_d       = dec;
        out_valid_d = 1'b1;
      end
    end else if (!skid_valid_q) begin
      if (in_fire && out_fire) begin
        out_d = dec;
      end else if (in_fire) begin
        skid_d       = dec;
        skid_valid_d = 1'b1;
      end else if (out_fire) begin
        out_valid_d = 1'b0;
      end
    end else if (out_fire) begin
      out_d        = skid_q;
      skid_valid_d = 1'b0;
    end
  end

`ifdef ID_DECODE_ILLEGAL_EN
  logic illegal_seen_d, illegal_seen_q;

  always_comb begin
    illegal_seen_d = illegal_seen_q | (out_fire & out_q.illegal);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) illegal_seen_q <= 1'b0;
    else     illegal_seen_q <= illegal_seen_d;
  end

  assign out_illegal  = out_q.illegal;
  assign illegal_seen = illegal_seen_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign in_ready      = ~skid_valid_q;
  assign out_valid     = out_valid_q;
  assign out_op2       = out_q.op2;
  assign out_imm_12    = out_q.imm_12;
  assign out_imm_20    = out_q.imm_20;
  assign out_rs1       = out_q.rs1;
  assign out_rs2       = out_q.rs2;
  assign out_rd        = out_q.rd;
  assign out_reg_write = out_q.reg_write;
  assign out_pc        = out_q.pc;

endmodule

// File: tb/tb_id_decode_stage.sv
// Table-driven bench for id_decode_stage with a scoreboard queue of expected decoded entries.
// Define ID_DECODE_ILLEGAL_EN to also exercise out_illegal and illegal_seen.
module tb_id_decode_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  out_op2;
  logic [11:0] out_imm_12;
  logic [19:0] out_imm_20;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic        out_reg_write;
  logic [31:0] out_pc;
`ifdef ID_DECODE_ILLEGAL_EN
  logic        out_illegal;
  logic        illegal_seen;
  logic        ill_seen_exp = 1'b0;
`endif

  id_decode_stage #(.XLEN(32), .OP_W(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op2(out_op2), .out_imm_12(out_imm_12), .out_imm_20(out_imm_20),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_pc(out_pc)
`ifdef ID_DECODE_ILLEGAL_EN
    , .out_illegal(out_illegal), .illegal_seen(illegal_seen)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  op2;
    logic [11:0] imm12;
    logic [19:0] imm20;
    logic [4:0]  rs1, rs2, rd;
    logic        rw;
`ifdef ID_DECODE_ILLEGAL_EN
    logic        ill;
`endif
  } vec_t;

  vec_t tbl [12];
  vec_t sb [$];
  vec_t cur_exp;
  int   checks = 0;
  int   failures = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic reportTimeout(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s timed out t=%0t", name, $time);
  endtask

  task automatic setVec(input int i, input logic [31:0] instr, input logic [4:0] op2,
                        input logic [11:0] imm12, input logic [19:0] imm20,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic rw);
    tbl[i].instr = instr;
    tbl[i].pc    = 32'h1000 + 32'(i * 4);
    tbl[i].op2   = op2;
    tbl[i].imm12 = imm12;
    tbl[i].imm20 = imm20;
    tbl[i].rs1   = rs1;
    tbl[i].rs2   = rs2;
    tbl[i].rd    = rd;
    tbl[i].rw    = rw;
`ifdef ID_DECODE_ILLEGAL_EN
    tbl[i].ill   = 1'b0;
`endif
  endtask

  // Scoreboard monitor: samples on the falling edge, models what the next rising edge will do.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
`ifdef ID_DECODE_ILLEGAL_EN
      ill_seen_exp = 1'b0;
`endif
    end else begin
      checkOutput("out_valid", 64'(out_valid), 64'(sb.size() > 0));
      checkOutput("in_ready", 64'(in_ready), 64'(sb.size() < 2));
`ifdef ID_DECODE_ILLEGAL_EN
      checkOutput("illegal_seen", 64'(illegal_seen), 64'(ill_seen_exp));
`endif
      if (out_valid && sb.size() > 0) begin
        checkOutput("op2", 64'(out_op2), 64'(sb[0].op2));
        checkOutput("imm_12", 64'(out_imm_12), 64'(sb[0].imm12));
        checkOutput("imm_20", 64'(out_imm_20), 64'(sb[0].imm20));
        checkOutput("rs1", 64'(out_rs1), 64'(sb[0].rs1));
        checkOutput("rs2", 64'(out_rs2), 64'(sb[0].rs2));
        checkOutput("rd", 64'(out_rd), 64'(sb[0].rd));
        checkOutput("reg_write", 64'(out_reg_write), 64'(sb[0].rw));
        checkOutput("pc", 64'(out_pc), 64'(sb[0].pc));
`ifdef ID_DECODE_ILLEGAL_EN
        checkOutput("out_illegal", 64'(out_illegal), 64'(sb[0].ill));
`endif
        if (out_ready) begin
`ifdef ID_DECODE_ILLEGAL_EN
          if (sb[0].ill) ill_seen_exp = 1'b1;
`endif
          void'(sb.pop_front());
        end
      end
      if (in_valid && in_ready && !flush) sb.push_back(cur_exp);
      if (flush) sb.delete();
    end
  end

  // Presents one table entry and holds it until accepted; returns at posedge+1.
  task automatic applyStimulus(input int idx);
    bit taken = 1'b0;
    cur_exp  = tbl[idx];
    in_instr = tbl[idx].instr;
    in_pc    = tbl[idx].pc;
    in_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) begin
        taken = 1'b1;
        break;
      end
    end
    if (!taken) reportTimeout("accept");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) reportTimeout("drain");
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    setVec(0,  32'h00412083, 5'd1, 12'h004, 20'h0,     5'd2, 5'd4,  5'd1,  1'b1);
    setVec(1,  32'h00112423, 5'd2, 12'h008, 20'h0,     5'd2, 5'd1,  5'd8,  1'b0);
    setVec(2,  32'h4030D093, 5'd3, 12'h403, 20'h0,     5'd1, 5'd3,  5'd1,  1'b1);
    setVec(3,  32'h123450B7, 5'd4, 12'h000, 20'h12345, 5'd8, 5'd3,  5'd1,  1'b1);
    setVec(4,  32'h00000000, 5'd0, 12'h000, 20'h0,     5'd0, 5'd0,  5'd0,  1'b0);
    setVec(5,  32'h00000033, 5'd0, 12'h000, 20'h0,     5'd0, 5'd0,  5'd0,  1'b0);
    setVec(6,  32'h0030D093, 5'd0, 12'h000, 20'h0,     5'd1, 5'd3,  5'd1,  1'b0);
    setVec(7,  32'h00410083, 5'd0, 12'h000, 20'h0,     5'd2, 5'd4,  5'd1,  1'b0);
    setVec(8,  32'hFFF12083, 5'd1, 12'hFFF, 20'h0,     5'd2, 5'd31, 5'd1,  1'b1);
    setVec(9,  32'hFE112E23, 5'd2, 12'hFFC, 20'h0,     5'd2, 5'd1,  5'd28, 1'b0);
    setVec(10, 32'h00000013, 5'd0, 12'h000, 20'h0,     5'd0, 5'd0,  5'd0,  1'b0);
    setVec(11, 32'h00000002, 5'd0, 12'h000, 20'h0,     5'd0, 5'd0,  5'd0,  1'b0);
`ifdef ID_DECODE_ILLEGAL_EN
    tbl[4].ill  = 1'b1;
    tbl[11].ill = 1'b1;
`endif

    // Reset values
    #1 rst = 1'b1;
    #1;
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_op2", 64'(out_op2), 64'd0);
    checkOutput("rst_pc", 64'(out_pc), 64'd0);
    checkOutput("rst_imm_20", 64'(out_imm_20), 64'd0);
`ifdef ID_DECODE_ILLEGAL_EN
    checkOutput("rst_illegal_seen", 64'(illegal_seen), 64'd0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;

    // Back-to-back stream of every table entry with downstream always ready
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) applyStimulus(i);
    drain();

    // Stall: two accepts fill the buffer, then release and check FIFO order
    out_ready = 1'b0;
    applyStimulus(0);
    applyStimulus(1);
    idle(3);
    out_ready = 1'b1;
    drain();

    // Flush from FULL with a new input presented
    out_ready = 1'b0;
    applyStimulus(2);
    applyStimulus(3);
    cur_exp  = tbl[8];
    in_instr = tbl[8].instr;
    in_pc    = tbl[8].pc;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("flush_out_valid", 64'(out_valid), 64'd0);
    checkOutput("flush_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    idle(4);

    // Flush from LOAD1 where the presented input would otherwise be accepted
    out_ready = 1'b0;
    applyStimulus(9);
    cur_exp  = tbl[1];
    in_instr = tbl[1].instr;
    in_pc    = tbl[1].pc;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    idle(4);

    // Reset in the middle of a full buffer
    out_ready = 1'b0;
    applyStimulus(5);
    applyStimulus(6);
    rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("midrst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("midrst_op2", 64'(out_op2), 64'd0);
`ifdef ID_DECODE_ILLEGAL_EN
    checkOutput("midrst_illegal_seen", 64'(illegal_seen), 64'd0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    idle(3);

    // Illegal word after reset, then a flush that must not clear the sticky flag
    applyStimulus(4);
    applyStimulus(3);
    drain();
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    idle(3);
    applyStimulus(0);
    drain();
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
